// File: rtl/corr_uart_framer.sv
// Correlator-to-UART framer: gathers NUM_WORDS words, then emits SYNC0, SYNC1 and the words MSB-byte first.
// Optional trailing XOR checksum byte when FRAMER_CHECKSUM_EN is defined.
module corr_uart_framer #(
    parameter int         WORD_W    = 24,
    parameter int         NUM_WORDS = 4,
    parameter logic [7:0] SYNC0     = 8'hA5,
    parameter logic [7:0] SYNC1     = 8'h5A,
    parameter int         GUARD_CYC = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        tx_din,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              frame_busy,
    output logic              frame_sent,
    output logic              overrun
);

    localparam int BPW   = WORD_W / 8;
    localparam int NDATA = NUM_WORDS * BPW;
`ifdef FRAMER_CHECKSUM_EN
    localparam int TOTAL = NDATA + 3;
`else
    localparam int TOTAL = NDATA + 2;
`endif
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int WC_W  = $clog2(NUM_WORDS + 1);
    localparam int GW    = $clog2(GUARD_CYC + 2);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
    localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(NUM_WORDS - 1);
    localparam logic [GW-1:0]    GUARD_MAX = GW'(GUARD_CYC);

    typedef enum logic [1:0] {FILL, SEND, WAIT, DONE} state_t;

    state_t             state;
    logic [WC_W-1:0]    word_cnt;
    logic [IDX_W-1:0]   byte_idx;
    logic [GW-1:0]      guard_cnt;
    logic [WORD_W-1:0]  buffer [NUM_WORDS];
    logic [NDATA*8-1:0] flat;
    logic [IDX_W-1:0]   issue_idx;
    logic [7:0]         issue_byte;
    logic               guard_ok;
    logic               accept;
    logic               last_word;

`ifdef FRAMER_CHECKSUM_EN
    logic [7:0] csum;
    logic       issue_is_data;
    assign issue_is_data = (issue_idx >= IDX_W'(2)) && (issue_idx < IDX_W'(NDATA + 2));
`endif

    assign guard_ok  = (guard_cnt == GUARD_MAX);
    assign accept    = in_valid && in_ready;
    assign last_word = (word_cnt == LAST_WORD);

    // Word 0 lands in the most significant slice so data bytes read out MSB-first in index order
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_flat
        assign flat[(NUM_WORDS-1-g)*WORD_W +: WORD_W] = buffer[g];
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (accept && word_cnt == WC_W'(w)) buffer[w] <= in_data;
        end
    end

    // The byte about to be issued: first byte from FILL/SEND, the following one from WAIT
    assign issue_idx = (state == WAIT) ? byte_idx + IDX_W'(1) : '0;

    always_comb begin
        issue_byte = 8'h00;
        if (issue_idx == '0) issue_byte = SYNC0;
        if (issue_idx == IDX_W'(1)) issue_byte = SYNC1;
        for (int i = 0; i < NDATA; i++) begin
            if (issue_idx == IDX_W'(i + 2)) issue_byte = flat[(NDATA-1-i)*8 +: 8];
        end
`ifdef FRAMER_CHECKSUM_EN
        if (issue_idx == IDX_W'(NDATA + 2)) issue_byte = csum;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            word_cnt   <= '0;
            byte_idx   <= '0;
            guard_cnt  <= '0;
            in_ready   <= 1'b0;
            tx_din     <= 8'h00;
            tx_start   <= 1'b0;
            frame_busy <= 1'b0;
            frame_sent <= 1'b0;
            overrun    <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            tx_start   <= 1'b0;
            frame_sent <= 1'b0;
            if (!guard_ok) guard_cnt <= guard_cnt + GW'(1);
            if (in_valid && !in_ready) overrun <= 1'b1;

            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    byte_idx <= '0;
`ifdef FRAMER_CHECKSUM_EN
                    csum     <= 8'h00;
`endif
                    if (accept) begin
                        word_cnt <= word_cnt + WC_W'(1);
                        if (last_word) begin
                            in_ready <= 1'b0;
                            // Issue the first sync byte right away so it appears the cycle after the last word
                            if (guard_ok) begin
                                tx_din     <= issue_byte;
                                tx_start   <= 1'b1;
                                frame_busy <= 1'b1;
                                state      <= WAIT;
                            end else begin
                                state <= SEND;
                            end
                        end
                    end
                end
                SEND: begin
                    if (guard_ok) begin
                        tx_din     <= issue_byte;
                        tx_start   <= 1'b1;
                        frame_busy <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // A tx_done coinciding with our own tx_start belongs to an older byte
                    if (tx_done && !tx_start) begin
                        if (byte_idx == LAST_IDX) begin
                            frame_sent <= 1'b1;
                            frame_busy <= 1'b0;
                            state      <= DONE;
                        end else begin
                            byte_idx <= issue_idx;
                            tx_din   <= issue_byte;
                            tx_start <= 1'b1;
`ifdef FRAMER_CHECKSUM_EN
                            if (issue_is_data) csum <= csum ^ issue_byte;
`endif
                        end
                    end
                end
                DONE: begin
                    word_cnt <= '0;
                    byte_idx <= '0;
                    in_ready <= 1'b1;
                    state    <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_corr_uart_framer.sv
// Scoreboard bench for corr_uart_framer (WORD_W=24, NUM_WORDS=2); honours FRAMER_CHECKSUM_EN.
module tb_corr_uart_framer;

    localparam int WORD_W    = 24;
    localparam int NUM_WORDS = 2;
    localparam int GUARD_CYC = 12;
    localparam int ACK_DELAY = 10;

    logic              clk;
    logic              rst_n;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        tx_din;
    logic              tx_start;
    logic              tx_done;
    logic              frame_busy;
    logic              frame_sent;
    logic              overrun;

    logic model_done, spur_done, spur_fill, spur_arm;
    assign tx_done = model_done | spur_done | spur_fill;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tcyc = 0;
    int ack_cnt;
    int byte_in_frame;
    int last_start;
    logic [7:0] exp_q [$];

    corr_uart_framer #(
        .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .SYNC0(8'hA5), .SYNC1(8'h5A), .GUARD_CYC(GUARD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_din(tx_din), .tx_start(tx_start), .tx_done(tx_done), .frame_busy(frame_busy),
        .frame_sent(frame_sent), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            tcyc++;
            if (!rst_n) cyc = 0;
            else cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Transmitter model: acknowledges each tx_start ACK_DELAY cycles later
    initial begin
        model_done = 1'b0;
        spur_done  = 1'b0;
        ack_cnt    = 0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            spur_done  = 1'b0;
            if (!rst_n) ack_cnt = 0;
            else begin
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) model_done = 1'b1;
                end
                if (tx_start) begin
                    ack_cnt = ACK_DELAY;
                    if (spur_arm) begin
                        spur_done = 1'b1;
                        spur_arm  = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every tx_start
    initial begin
        logic [7:0] e;
        byte_in_frame = 0;
        last_start    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) byte_in_frame = 0;
            else begin
                if (tx_start) begin
                    checkOutput("busy_at_start", frame_busy, 1);
                    checkOutput("guard_respected", cyc >= GUARD_CYC, 1);
                    if (byte_in_frame > 0) checkOutput("byte_gap", tcyc - last_start, ACK_DELAY + 1);
                    last_start = tcyc;
                    byte_in_frame++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_byte actual=%0h required=none", tx_din);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("tx_din", tx_din, e);
                    end
                end
                if (frame_sent) byte_in_frame = 0;
            end
        end
    end

    task automatic pushWord(input logic [WORD_W-1:0] w, inout logic [7:0] x);
        logic [7:0] v;
        for (int b = WORD_W/8 - 1; b >= 0; b--) begin
            v = w[8*b +: 8];
            exp_q.push_back(v);
            x = x ^ v;
        end
    endtask

    task automatic applyStimulus(input logic [WORD_W-1:0] w);
        int n = 0;
        while (!in_ready && n < 200) begin
            in_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("in_ready_wait", in_ready, 1);
        else begin
            in_valid = 1'b1;
            in_data  = w;
            @(negedge clk);
        end
    endtask

    task automatic sendFrame(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1, input bit chk_lat);
        logic [7:0] x = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        pushWord(w0, x);
        pushWord(w1, x);
`ifdef FRAMER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        applyStimulus(w0);
        checkOutput("busy_low_in_fill", frame_busy, 0);
        applyStimulus(w1);
        in_valid = 1'b0;
        if (chk_lat) checkOutput("first_start_latency", tx_start, 1);
    endtask

    task automatic waitFrame();
        int n = 0;
        while (!frame_sent && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_sent_seen", frame_sent, 1);
        checkOutput("busy_low_on_sent", frame_busy, 0);
        checkOutput("bytes_left", exp_q.size(), 0);
        @(negedge clk);
        checkOutput("frame_sent_pulse", frame_sent, 0);
        checkOutput("in_ready_after_done", in_ready, 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_tx_din"}, tx_din, 0);
        checkOutput({tag, "_tx_start"}, tx_start, 0);
        checkOutput({tag, "_frame_busy"}, frame_busy, 0);
        checkOutput({tag, "_frame_sent"}, frame_sent, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        spur_fill = 1'b0;
        spur_arm  = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Spurious tx_done in FILL, then a basic frame with tx_done coinciding with its first tx_start
        spur_fill = 1'b1;
        @(negedge clk);
        spur_fill = 1'b0;
        spur_arm  = 1'b1;
        sendFrame(24'h123456, 24'hABCDEF, 1'b1);
        waitFrame();

        // Input held valid during transmission must be dropped and flagged
        sendFrame(24'hC0FFEE, 24'h102030, 1'b1);
        checkOutput("overrun_clear", overrun, 0);
        checkOutput("in_ready_low_busy", in_ready, 0);
        @(negedge clk);
        in_data  = 24'h000001;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("overrun_set", overrun, 1);
        checkOutput("in_ready_still_low", in_ready, 0);
        waitFrame();
        sendFrame(24'h0F0F0F, 24'h800000, 1'b1);
        waitFrame();
        checkOutput("overrun_sticky", overrun, 1);

        // Reset after the third byte's tx_start
        sendFrame(24'h111111, 24'h222222, 1'b1);
        n = tx_start ? 1 : 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge clk);
            if (tx_start) n++;
        end
        checkOutput("third_start_seen", n, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Frame filled right after release waits out the guard and restarts at A5
        sendFrame(24'h654321, 24'h00FF00, 1'b0);
        checkOutput("held_by_guard", tx_start, 0);
        waitFrame();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
